// File: rtl/svm_pkg.sv
// svm_pkg: shared types for the SVM inference controller and its memory-side
// command engine.
//   t_mem_cmds  - 4-bit command codes sent on mem_cmd
//   t_mem_resp  - 3-bit response codes returned on mem_resp
//   t_eng_state - command-engine FSM states
//   LANES_DEF   - default compute-array width
package svm_pkg;

  localparam int LANES_DEF = 32;

  typedef enum logic [3:0] {
    LOAD_WEIGHTS_NUM    = 4'd0,
    LOAD_WEIGHTS_FULL   = 4'd1,
    LOAD_DATA_NUM       = 4'd2,
    LOAD_DATA_FULL      = 4'd3,
    WR_TO_SCRATCH_STACK = 4'd4,
    WR_INFER_RES        = 4'd5,
    POP_SCRATCH_STACK   = 4'd6
  } t_mem_cmds;

  typedef enum logic [2:0] {
    WGHT_LOAD_DONE      = 3'd0,
    DATAVEC_LOAD_DONE   = 3'd1,
    WR_INFER_RES_DONE   = 3'd2,
    SCRATCH_1_PUSH_DONE = 3'd3,
    SCRATCH_1_POP_DONE  = 3'd4,
    ERR                 = 3'd7
  } t_mem_resp;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BURST = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } t_eng_state;

endpackage

// File: rtl/svm_sram_burst_rd.sv
// svm_sram_burst_rd: issues one SRAM read per lane for a LANES-beat burst and
// aligns the 1-cycle-late read data onto the array programming bus.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, base, cnt    - burst start pulse, first address, number of real lanes
//   wghtbar             - lane type for this burst (0 weight, 1 data)
//   sram_rdata          - SRAM read data (valid the cycle after rd_req)
//   rd_req, rd_addr     - SRAM read request/address
//   prog_*              - programming beat (valid, lane type, index, value)
import svm_pkg::*;

module svm_sram_burst_rd #(
  parameter int ADDR_W = 16,
  parameter int LANES  = LANES_DEF,
  localparam int IW    = $clog2(LANES),
  localparam int NW    = $clog2(LANES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [NW-1:0]     cnt,
  input  logic              wghtbar,
  input  logic [31:0]       sram_rdata,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              prog_vld,
  output logic              prog_wghtbar_data,
  output logic [4:0]        prog_idx,
  output logic [31:0]       prog_data
);

  logic          active;
  logic [IW-1:0] lane;
  logic [NW-1:0] n_lanes;
  logic          wb;
  logic          pad;

  // Lane sequencer plus one-stage beat pipeline; a lane with no read is a pad.
  always_ff @(posedge clk) begin
    if (rst) begin
      active            <= 1'b0;
      lane              <= '0;
      n_lanes           <= '0;
      wb                <= 1'b0;
      rd_req            <= 1'b0;
      rd_addr           <= '0;
      prog_vld          <= 1'b0;
      prog_wghtbar_data <= 1'b0;
      prog_idx          <= 5'd0;
      pad               <= 1'b1;
    end else begin
      prog_vld          <= active;
      prog_idx          <= active ? 5'(lane) : 5'd0;
      prog_wghtbar_data <= active ? wb : 1'b0;
      pad               <= ~rd_req;
      if (start) begin
        active  <= 1'b1;
        lane    <= '0;
        n_lanes <= cnt;
        wb      <= wghtbar;
        rd_req  <= (cnt != '0);
        rd_addr <= base;
      end else if (active) begin
        if (lane == IW'(LANES - 1)) begin
          active <= 1'b0;
          rd_req <= 1'b0;
        end else begin
          lane    <= lane + IW'(1);
          rd_req  <= ((NW'(lane) + NW'(1)) < n_lanes);
          rd_addr <= rd_addr + ADDR_W'(1);
        end
      end else begin
        rd_req <= 1'b0;
      end
    end
  end

  // Read data arrives in the beat cycle itself, so it is muxed straight through.
  assign prog_data = (prog_vld && !pad) ? sram_rdata : 32'd0;

endmodule

// File: rtl/svm_mem_cmd_engine.sv
// svm_mem_cmd_engine: services mem_cmd requests from the SVM inference
// controller: weight/data loads onto the programming bus, scratch-stack
// push/pop and inference-result writes, one mem_resp per command.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   cfg_load, *_BASE             - latch region bases and rewind pointers
//   mem_cmd_vld/mem_cmd/_data    - held command from the controller
//   mem_resp_vld/mem_resp/_data  - one-cycle response pulse
//   sram_*                       - single-port SRAM, 1-cycle read latency
//   prog_*                       - programming bus to the compute array
//   err                          - sticky error flag
import svm_pkg::*;

module svm_mem_cmd_engine #(
  parameter int ADDR_W      = 16,
  parameter int LANES       = LANES_DEF,
  parameter int STACK_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] WGHT_BASE,
  input  logic [ADDR_W-1:0] DATA_BASE,
  input  logic [ADDR_W-1:0] SCRATCH_BASE,
  input  logic [ADDR_W-1:0] RES_BASE,
  input  logic              mem_cmd_vld,
  input  logic [3:0]        mem_cmd,
  input  logic [31:0]       mem_cmd_data,
  output logic              mem_resp_vld,
  output logic [2:0]        mem_resp,
  output logic [31:0]       mem_resp_data,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              prog_vld,
  output logic              prog_wghtbar_data,
  output logic [4:0]        prog_idx,
  output logic [31:0]       prog_data,
  output logic              err
);

  localparam int IW = $clog2(LANES);
  localparam int NW = $clog2(LANES + 1);
  localparam int SW = $clog2(STACK_DEPTH + 1);

  t_eng_state        state;
  t_mem_resp         resp_code;
  logic [31:0]       resp_data;
  logic [IW-1:0]     cnt;
  logic [ADDR_W-1:0] wptr, dptr, rptr;
  logic [SW-1:0]     sp;
  logic [ADDR_W-1:0] wght_base_lat, scratch_base_lat, res_base_lat;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  logic              accept;
  logic [NW-1:0]     req_n, pop_n;
  logic              bst_start, bst_wb;
  logic [ADDR_W-1:0] bst_base;
  logic [NW-1:0]     bst_n;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;

  assign accept = (state == IDLE) && mem_cmd_vld && !cfg_load;

  // Lane counts: requested count clipped to LANES, and for pops also to sp.
  always_comb begin
    req_n = (mem_cmd_data > 32'(LANES)) ? NW'(LANES) : NW'(mem_cmd_data);
    if (32'(req_n) > 32'(sp)) begin
      pop_n = NW'(sp);
    end else begin
      pop_n = req_n;
    end
  end

  // Burst launch parameters for an accepted load or pop.
  always_comb begin
    bst_start = 1'b0;
    bst_wb    = 1'b0;
    bst_base  = '0;
    bst_n     = '0;
    if (accept) begin
      case (mem_cmd)
        LOAD_WEIGHTS_NUM:  begin bst_start = 1'b1; bst_base = wptr; bst_n = req_n; end
        LOAD_WEIGHTS_FULL: begin bst_start = 1'b1; bst_base = wptr; bst_n = NW'(LANES); end
        LOAD_DATA_NUM:     begin bst_start = 1'b1; bst_wb = 1'b1; bst_base = dptr; bst_n = req_n; end
        LOAD_DATA_FULL:    begin bst_start = 1'b1; bst_wb = 1'b1; bst_base = dptr; bst_n = NW'(LANES); end
        POP_SCRATCH_STACK: begin
          bst_start = 1'b1;
          bst_wb    = 1'b1;
          bst_base  = scratch_base_lat + ADDR_W'(sp) - ADDR_W'(pop_n);
          bst_n     = pop_n;
        end
        default: bst_start = 1'b0;
      endcase
    end else begin
      bst_start = 1'b0;
    end
  end

  svm_sram_burst_rd #(.ADDR_W(ADDR_W), .LANES(LANES)) u_burst (
    .clk               (clk),
    .rst               (rst),
    .start             (bst_start),
    .base              (bst_base),
    .cnt               (bst_n),
    .wghtbar           (bst_wb),
    .sram_rdata        (sram_rdata),
    .rd_req            (rd_req),
    .rd_addr           (rd_addr),
    .prog_vld          (prog_vld),
    .prog_wghtbar_data (prog_wghtbar_data),
    .prog_idx          (prog_idx),
    .prog_data         (prog_data)
  );

  // Reads and writes come from disjoint FSM states, so they never overlap.
  assign sram_req   = rd_req | wr_req;
  assign sram_we    = wr_req;
  assign sram_addr  = wr_req ? wr_addr : rd_addr;
  assign sram_wdata = wr_req ? wr_data : 32'd0;

  // Command FSM, pointer bookkeeping, error flag and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;  resp_code <= WGHT_LOAD_DONE;  resp_data <= 32'd0;  cnt <= '0;
      wptr <= '0;  dptr <= '0;  rptr <= '0;  sp <= '0;
      wght_base_lat <= '0;  scratch_base_lat <= '0;  res_base_lat <= '0;
      wr_req <= 1'b0;  wr_addr <= '0;  wr_data <= 32'd0;
      mem_resp_vld <= 1'b0;  mem_resp <= 3'd0;  mem_resp_data <= 32'd0;  err <= 1'b0;
    end else begin
      if (cfg_load && state != IDLE) begin
        err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cfg_load) begin
            wght_base_lat    <= WGHT_BASE;
            scratch_base_lat <= SCRATCH_BASE;
            res_base_lat     <= RES_BASE;
            wptr <= WGHT_BASE;  dptr <= DATA_BASE;  sp <= '0;  rptr <= '0;
            err  <= 1'b0;
          end else if (mem_cmd_vld) begin
            cnt <= '0;
            case (mem_cmd)
              LOAD_WEIGHTS_NUM: begin
                state <= BURST;  resp_code <= WGHT_LOAD_DONE;  resp_data <= 32'(req_n);
                wptr  <= wght_base_lat;  // closes the data point
              end
              LOAD_WEIGHTS_FULL: begin
                state <= BURST;  resp_code <= WGHT_LOAD_DONE;  resp_data <= 32'(LANES);
                wptr  <= wptr + ADDR_W'(LANES);
              end
              LOAD_DATA_NUM: begin
                state <= BURST;  resp_code <= DATAVEC_LOAD_DONE;  resp_data <= 32'(req_n);
                dptr  <= dptr + ADDR_W'(req_n);
              end
              LOAD_DATA_FULL: begin
                state <= BURST;  resp_code <= DATAVEC_LOAD_DONE;  resp_data <= 32'(LANES);
                dptr  <= dptr + ADDR_W'(LANES);
              end
              POP_SCRATCH_STACK: begin
                state <= BURST;  resp_code <= SCRATCH_1_POP_DONE;  resp_data <= 32'(pop_n);
                sp    <= sp - SW'(pop_n);
                if (mem_cmd_data > 32'(sp)) begin
                  err <= 1'b1;
                end
              end
              WR_TO_SCRATCH_STACK: begin
                state <= WRITE;
                if (sp == SW'(STACK_DEPTH)) begin
                  resp_code <= ERR;  resp_data <= 32'(sp);  err <= 1'b1;
                end else begin
                  wr_req    <= 1'b1;
                  wr_addr   <= scratch_base_lat + ADDR_W'(sp);
                  wr_data   <= mem_cmd_data;
                  sp        <= sp + SW'(1);
                  resp_code <= SCRATCH_1_PUSH_DONE;
                  resp_data <= 32'(sp) + 32'd1;
                end
              end
              WR_INFER_RES: begin
                state     <= WRITE;
                wr_req    <= 1'b1;
                wr_addr   <= res_base_lat + rptr;
                wr_data   <= {31'd0, mem_cmd_data[0]};
                rptr      <= rptr + ADDR_W'(1);
                resp_code <= WR_INFER_RES_DONE;
                resp_data <= 32'(rptr);
              end
              default: begin
                // Unknown code: answer immediately, no SRAM access.
                state <= RESP;  mem_resp_vld <= 1'b1;  mem_resp <= ERR;
                mem_resp_data <= 32'd0;  err <= 1'b1;
              end
            endcase
          end else begin
            state <= IDLE;
          end
        end
        BURST: begin
          if (cnt == IW'(LANES - 1)) begin
            state <= DRAIN;
          end else begin
            cnt <= cnt + IW'(1);
          end
        end
        DRAIN, WRITE: begin
          wr_req        <= 1'b0;
          state         <= RESP;
          mem_resp_vld  <= 1'b1;
          mem_resp      <= resp_code;
          mem_resp_data <= resp_data;
        end
        RESP: begin
          state         <= IDLE;
          mem_resp_vld  <= 1'b0;
          mem_resp      <= 3'd0;
          mem_resp_data <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_mem_cmd_engine.sv
// Directed self-checking bench for svm_mem_cmd_engine with a behavioural
// 1-cycle-latency SRAM. Unwritten SRAM words return a pattern derived from
// their address so load data is known without preloading.
import svm_pkg::*;

module tb_svm_mem_cmd_engine;

  localparam int ADDR_W = 16;
  localparam int LANES  = 32;
  localparam int STACK_DEPTH = 256;

  logic clk = 1'b0, rst = 1'b1, cfg_load = 1'b0;
  logic [ADDR_W-1:0] wght_base = 16'h0100, data_base = 16'h0200;
  logic [ADDR_W-1:0] scratch_base = 16'h0300, res_base = 16'h0400;
  logic mem_cmd_vld = 1'b0;
  logic [3:0] mem_cmd = 4'd0;
  logic [31:0] mem_cmd_data = 32'd0;
  logic mem_resp_vld, sram_req, sram_we, prog_vld, prog_wghtbar_data, err;
  logic [2:0] mem_resp;
  logic [31:0] mem_resp_data, sram_wdata, sram_rdata, prog_data;
  logic [ADDR_W-1:0] sram_addr;
  logic [4:0] prog_idx;

  int checks = 0, errors = 0, cyc = 0;
  int nreads = 0, nwrites = 0, nresp = 0;
  logic [31:0] beat_data [0:31];
  logic        beat_wb   [0:31];
  int          beat_cyc  [0:31];
  logic [31:0] exp_beat  [0:31];
  logic [31:0] mem [0:65535];
  bit          wr_flag [0:65535];

  svm_mem_cmd_engine #(.ADDR_W(ADDR_W), .LANES(LANES), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load),
    .WGHT_BASE(wght_base), .DATA_BASE(data_base), .SCRATCH_BASE(scratch_base), .RES_BASE(res_base),
    .mem_cmd_vld(mem_cmd_vld), .mem_cmd(mem_cmd), .mem_cmd_data(mem_cmd_data),
    .mem_resp_vld(mem_resp_vld), .mem_resp(mem_resp), .mem_resp_data(mem_resp_data),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .prog_vld(prog_vld), .prog_wghtbar_data(prog_wghtbar_data),
    .prog_idx(prog_idx), .prog_data(prog_data), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [15:0] a);
    return (a[15:8] == 8'h02) ? (32'h1000 + 32'(a[7:0])) : 32'(a[7:0]);
  endfunction

  // Behavioural SRAM
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        mem[sram_addr] <= sram_wdata;
        wr_flag[sram_addr] <= 1'b1;
      end else begin
        sram_rdata <= wr_flag[sram_addr] ? mem[sram_addr] : pat(sram_addr);
      end
    end
  end

  // Bus monitor
  always @(negedge clk) begin
    if (prog_vld) begin
      beat_data[prog_idx] = prog_data;
      beat_wb[prog_idx]   = prog_wghtbar_data;
      beat_cyc[prog_idx]  = cyc;
    end
    if (sram_req && !sram_we) nreads = nreads + 1;
    if (sram_req && sram_we)  nwrites = nwrites + 1;
    if (mem_resp_vld)         nresp = nresp + 1;
  end

  function automatic logic any_out();
    return |{mem_resp_vld, mem_resp, mem_resp_data, sram_req, sram_we, sram_addr,
             sram_wdata, prog_vld, prog_wghtbar_data, prog_idx, prog_data, err};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_cfg();
    @(negedge clk); cfg_load = 1'b1;
    @(negedge clk); cfg_load = 1'b0;
  endtask

  // Issue one command, hold it until the response, report code/data/latency/accesses.
  task automatic send_cmd(input logic [3:0] c, input logic [31:0] d,
                          output logic [2:0] rc, output logic [31:0] rd,
                          output int lat, output int reads, output int writes, output int c0);
    int r0, w0;
    bit got;
    @(negedge clk);
    r0 = nreads; w0 = nwrites;
    mem_cmd_vld = 1'b1; mem_cmd = c; mem_cmd_data = d; c0 = cyc;
    got = 1'b0; rc = 3'd6; rd = 32'hDEAD; lat = -1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (mem_resp_vld) begin
        got = 1'b1; rc = mem_resp; rd = mem_resp_data; lat = cyc - c0;
      end
    end
    mem_cmd_vld = 1'b0;
    reads = nreads - r0; writes = nwrites - w0;
    chk($sformatf("resp_seen_cmd%0d", c), 64'(got), 64'd1);
  endtask

  task automatic check_beats(input string tag, input int c0, input logic wb);
    for (int i = 0; i < LANES; i++) begin
      chk($sformatf("%s_data%0d", tag, i), 64'(beat_data[i]), 64'(exp_beat[i]));
      chk($sformatf("%s_cyc%0d", tag, i), 64'(beat_cyc[i]), 64'(c0 + 2 + i));
      chk($sformatf("%s_wb%0d", tag, i), 64'(beat_wb[i]), 64'(wb));
    end
  endtask

  initial begin
    logic [2:0] rc; logic [31:0] rd; int lat, rds, wrs, c0, bad, r0; bit hit;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(any_out()), 64'd0);
    chk("reset_state", 64'(dut.state), 64'(IDLE));
    rst = 1'b0;
    pulse_cfg();

    // Full weight load from 0x100
    send_cmd(4'd1, 32'd0, rc, rd, lat, rds, wrs, c0);
    chk("wf_code", 64'(rc), 64'd0);
    chk("wf_lat", 64'(lat), 64'd34);
    chk("wf_n", 64'(rd), 64'd32);
    chk("wf_reads", 64'(rds), 64'd32);
    for (int i = 0; i < LANES; i++) exp_beat[i] = 32'(i);
    check_beats("wf", c0, 1'b0);
    chk("wf_wptr", 64'(dut.wptr), 64'h120);

    // Partial data load, 5 lanes
    send_cmd(4'd2, 32'd5, rc, rd, lat, rds, wrs, c0);
    chk("dn_code", 64'(rc), 64'd1);
    chk("dn_n", 64'(rd), 64'd5);
    chk("dn_reads", 64'(rds), 64'd5);
    chk("dn_lat", 64'(lat), 64'd34);
    for (int i = 0; i < LANES; i++) exp_beat[i] = (i < 5) ? 32'h1000 + 32'(i) : 32'd0;
    check_beats("dn", c0, 1'b1);

    // Weight NUM request above LANES clips to 32 and rewinds wptr
    send_cmd(4'd0, 32'd40, rc, rd, lat, rds, wrs, c0);
    chk("wn_code", 64'(rc), 64'd0);
    chk("wn_n", 64'(rd), 64'd32);
    for (int i = 0; i < LANES; i++) exp_beat[i] = 32'h20 + 32'(i);
    check_beats("wn", c0, 1'b0);
    chk("wn_wptr_rewind", 64'(dut.wptr), 64'h100);

    // Three pushes
    for (int k = 0; k < 3; k++) begin
      send_cmd(4'd4, 32'hA + 32'(k), rc, rd, lat, rds, wrs, c0);
      chk("push_code", 64'(rc), 64'd3);
      chk("push_sp", 64'(rd), 64'(k + 1));
      chk("push_lat", 64'(lat), 64'd2);
      chk("push_writes", 64'(wrs), 64'd1);
      chk("push_mem", 64'(mem[16'h0300 + 16'(k)]), 64'hA + 64'(k));
    end
    chk("err_before_pop", 64'(err), 64'd0);

    // Over-sized pop
    send_cmd(4'd6, 32'd32, rc, rd, lat, rds, wrs, c0);
    chk("pop_code", 64'(rc), 64'd4);
    chk("pop_n", 64'(rd), 64'd3);
    chk("pop_reads", 64'(rds), 64'd3);
    for (int i = 0; i < LANES; i++) exp_beat[i] = (i < 3) ? 32'hA + 32'(i) : 32'd0;
    check_beats("pop", c0, 1'b1);
    chk("pop_err", 64'(err), 64'd1);
    chk("pop_sp", 64'(dut.sp), 64'd0);

    pulse_cfg();
    chk("cfg_clears_err", 64'(err), 64'd0);

    // Inference results: bit 0 only
    for (int k = 0; k < 3; k++) begin
      send_cmd(4'd5, (k == 0) ? 32'h3 : 32'(k - 1), rc, rd, lat, rds, wrs, c0);
      chk("res_code", 64'(rc), 64'd2);
      chk("res_old_rptr", 64'(rd), 64'(k));
      chk("res_mem", 64'(mem[16'h0400 + 16'(k)]), (k == 1) ? 64'd0 : 64'd1);
    end

    // Unknown command
    send_cmd(4'd9, 32'd0, rc, rd, lat, rds, wrs, c0);
    chk("unk_code", 64'(rc), 64'd7);
    chk("unk_lat", 64'(lat), 64'd1);
    chk("unk_access", 64'(rds + wrs), 64'd0);
    chk("unk_err", 64'(err), 64'd1);

    // Fill the stack, then overflow it
    pulse_cfg();
    bad = 0;
    for (int k = 0; k < STACK_DEPTH; k++) begin
      send_cmd(4'd4, 32'(k), rc, rd, lat, rds, wrs, c0);
      if (rc !== 3'd3 || rd !== 32'(k + 1) || wrs != 1) bad++;
    end
    chk("fill_bad", 64'(bad), 64'd0);
    chk("fill_err", 64'(err), 64'd0);
    send_cmd(4'd4, 32'h55, rc, rd, lat, rds, wrs, c0);
    chk("ovf_code", 64'(rc), 64'd7);
    chk("ovf_writes", 64'(wrs), 64'd0);
    chk("ovf_err", 64'(err), 64'd1);

    // Reset during beat 10 of a full load
    pulse_cfg();
    @(negedge clk);
    mem_cmd_vld = 1'b1; mem_cmd = 4'd1; mem_cmd_data = 32'd0;
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      if (prog_vld && prog_idx == 5'd10) hit = 1'b1;
    end
    chk("rst_beat10_seen", 64'(hit), 64'd1);
    rst = 1'b1; mem_cmd_vld = 1'b0; r0 = nresp;
    @(negedge clk);
    chk("rst_abort_outputs", 64'(any_out()), 64'd0);
    chk("rst_abort_state", 64'(dut.state), 64'(IDLE));
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_abort_no_resp", 64'(nresp - r0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
